// File: rtl/axil_reg_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite register slave between two
// requesters, sequencing one single-word read or write at a time.
module axil_reg_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,

  input  logic                    req0_valid,
  input  logic                    req0_write,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_wstrb,
  output logic                    req0_ready,
  output logic                    req0_done,
  output logic [DATA_WIDTH-1:0]   req0_rdata,
  output logic [1:0]              req0_resp,

  input  logic                    req1_valid,
  input  logic                    req1_write,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_wstrb,
  output logic                    req1_ready,
  output logic                    req1_done,
  output logic [DATA_WIDTH-1:0]   req1_rdata,
  output logic [1:0]              req1_resp,

  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t state, next_state;

  logic                    last_grant;
  logic                    grant_id;
  logic                    accept;
  logic                    sel_write;
  logic [ADDR_WIDTH-3:0]   sel_word;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_wstrb;
  logic                    aw_fin;
  logic                    w_fin;
  logic                    awvalid_d;
  logic                    wvalid_d;
  logic                    arvalid_d;
  logic                    bready_d;
  logic                    rready_d;
  logic                    done_d;
  logic                    unused_addr_lsbs;

  // Byte-lane bits of the address never reach the slave.
  assign unused_addr_lsbs = ^{req0_addr[1:0], req1_addr[1:0]};

  always_comb begin
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
    accept = (state == IDLE) && (req0_valid || req1_valid);
  end

  assign sel_write = grant_id ? req1_write : req0_write;
  assign sel_word  = grant_id ? req1_addr[ADDR_WIDTH-1:2] : req0_addr[ADDR_WIDTH-1:2];
  assign sel_wdata = grant_id ? req1_wdata : req0_wdata;
  assign sel_wstrb = grant_id ? req1_wstrb : req0_wstrb;

  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept & grant_id;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // A channel counts as finished once its valid has dropped or is being taken now.
  assign aw_fin = ~m_axi_awvalid | m_axi_awready;
  assign w_fin  = ~m_axi_wvalid  | m_axi_wready;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = sel_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_fin && w_fin) next_state = WR_RESP;
      WR_RESP: if (m_axi_bvalid) next_state = IDLE;
      RD_REQ:  if (m_axi_arready) next_state = RD_RESP;
      RD_RESP: if (m_axi_rvalid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    arvalid_d = 1'b0;
    bready_d  = 1'b0;
    rready_d  = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        awvalid_d = accept & sel_write;
        wvalid_d  = accept & sel_write;
        arvalid_d = accept & ~sel_write;
      end
      WR_REQ: begin
        awvalid_d = m_axi_awvalid & ~m_axi_awready;
        wvalid_d  = m_axi_wvalid & ~m_axi_wready;
        bready_d  = aw_fin & w_fin;
      end
      WR_RESP: begin
        bready_d = ~m_axi_bvalid;
        done_d   = m_axi_bvalid;
      end
      RD_REQ: begin
        arvalid_d = ~m_axi_arready;
        rready_d  = m_axi_arready;
      end
      RD_RESP: begin
        rready_d = ~m_axi_rvalid;
        done_d   = m_axi_rvalid;
      end
      default: ;
    endcase
  end

  // last_grant doubles as the owner of the in-flight command.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      last_grant    <= 1'b1;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_araddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      req0_done     <= 1'b0;
      req1_done     <= 1'b0;
      req0_rdata    <= '0;
      req1_rdata    <= '0;
      req0_resp     <= 2'b00;
      req1_resp     <= 2'b00;
    end else begin
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_rready  <= rready_d;
      req0_done     <= done_d & ~last_grant;
      req1_done     <= done_d & last_grant;
      if (accept) begin
        last_grant <= grant_id;
        if (sel_write) begin
          m_axi_awaddr <= {sel_word, 2'b00};
          m_axi_wdata  <= sel_wdata;
          m_axi_wstrb  <= sel_wstrb;
        end else begin
          m_axi_araddr <= {sel_word, 2'b00};
        end
      end
      if (state == WR_RESP && m_axi_bvalid) begin
        if (last_grant) req1_resp <= m_axi_bresp;
        else            req0_resp <= m_axi_bresp;
      end
      if (state == RD_RESP && m_axi_rvalid) begin
        if (last_grant) begin
          req1_rdata <= m_axi_rdata;
          req1_resp  <= m_axi_rresp;
        end else begin
          req0_rdata <= m_axi_rdata;
          req0_resp  <= m_axi_rresp;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Directed bench for axil_reg_arbiter: two scripted requesters and a
// four-word AXI4-Lite register slave with adjustable handshake timing.
module tb_axil_reg_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [3:0]  req0_addr, req1_addr, req0_wstrb, req1_wstrb;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req0_done, req1_ready, req1_done;
  logic [31:0] req0_rdata, req1_rdata;
  logic [1:0]  req0_resp, req1_resp;

  logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [31:0] m_axi_wdata;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
  logic        m_axi_awready = 1'b0;
  logic        m_axi_wready  = 1'b0;
  logic        m_axi_arready = 1'b0;
  logic        m_axi_bvalid  = 1'b0;
  logic        m_axi_rvalid  = 1'b0;
  logic [1:0]  m_axi_bresp   = 2'b00;
  logic [1:0]  m_axi_rresp   = 2'b00;
  logic [31:0] m_axi_rdata   = 32'h0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         aw_wait   = 0;
  int         w_wait    = 0;
  bit         r_stall   = 1'b0;
  logic [1:0] rresp_cfg = 2'b00;
  logic [31:0] regs [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int aw_cycles = 0, w_cycles = 0, b_hs_cyc = 0;
  logic [3:0]  cap_awaddr = 4'h0, cap_araddr = 4'h0, cap_wstrb = 4'h0;
  logic [31:0] cap_wdata = 32'h0;
  int aw_used = 0, w_used = 0, ar_used = 0, b_seen = 0, r_seen = 0;
  int aw_cnt = 0, w_cnt = 0;

  always #5 ACLK = ~ACLK;

  axil_reg_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_ready(req0_ready),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_ready(req1_ready),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Handshake monitor: counts transfers and captures what the slave was handed.
  always @(posedge ACLK) begin
    if (m_axi_awvalid) aw_cycles <= aw_cycles + 1;
    if (m_axi_wvalid)  w_cycles  <= w_cycles + 1;
    if (m_axi_awvalid && m_axi_awready) begin
      aw_hs_n    <= aw_hs_n + 1;
      cap_awaddr <= m_axi_awaddr;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_hs_n    <= w_hs_n + 1;
      cap_wdata <= m_axi_wdata;
      cap_wstrb <= m_axi_wstrb;
    end
    if (m_axi_bvalid && m_axi_bready) begin
      b_hs_n   <= b_hs_n + 1;
      b_hs_cyc <= cyc;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      ar_hs_n    <= ar_hs_n + 1;
      cap_araddr <= m_axi_araddr;
    end
    if (m_axi_rvalid && m_axi_rready) r_hs_n <= r_hs_n + 1;
    cyc <= cyc + 1;
  end

  // Register slave, driven on the falling edge so it never races the DUT.
  always @(negedge ACLK) begin
    if (ARESET) begin
      m_axi_awready <= 1'b0;
      m_axi_wready  <= 1'b0;
      m_axi_arready <= 1'b0;
      m_axi_bvalid  <= 1'b0;
      m_axi_rvalid  <= 1'b0;
      aw_cnt  <= 0;
      w_cnt   <= 0;
      aw_used <= aw_hs_n;
      w_used  <= w_hs_n;
      ar_used <= ar_hs_n;
      b_seen  <= b_hs_n;
      r_seen  <= r_hs_n;
    end else begin
      if (m_axi_awvalid) begin
        m_axi_awready <= (aw_cnt >= aw_wait);
        if (aw_cnt < aw_wait) aw_cnt <= aw_cnt + 1;
      end else begin
        m_axi_awready <= 1'b0;
        aw_cnt <= 0;
      end
      if (m_axi_wvalid) begin
        m_axi_wready <= (w_cnt >= w_wait);
        if (w_cnt < w_wait) w_cnt <= w_cnt + 1;
      end else begin
        m_axi_wready <= 1'b0;
        w_cnt <= 0;
      end
      m_axi_arready <= m_axi_arvalid;
      if (m_axi_bvalid && b_hs_n != b_seen) begin
        m_axi_bvalid <= 1'b0;
        b_seen <= b_hs_n;
      end else if (!m_axi_bvalid && aw_hs_n != aw_used && w_hs_n != w_used) begin
        for (int i = 0; i < 4; i++)
          if (cap_wstrb[i]) regs[cap_awaddr[3:2]][8*i +: 8] <= cap_wdata[8*i +: 8];
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= 2'b00;
        aw_used <= aw_used + 1;
        w_used  <= w_used + 1;
      end
      if (m_axi_rvalid && r_hs_n != r_seen) begin
        m_axi_rvalid <= 1'b0;
        r_seen <= r_hs_n;
      end else if (!m_axi_rvalid && !r_stall && ar_hs_n != ar_used) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= regs[cap_araddr[3:2]];
        m_axi_rresp  <= rresp_cfg;
        ar_used <= ar_used + 1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one command from requester id and waits for its completion.
  task automatic apply_stimulus(input bit id, input bit wr, input logic [3:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                output logic [31:0] rdata, output logic [1:0] resp,
                                output int lat);
    bit got = 1'b0;
    bit fin = 1'b0;
    int acc_cyc = 0;
    rdata = 32'h0;
    resp  = 2'b00;
    lat   = -1;
    @(negedge ACLK);
    if (id) begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_wstrb = wstrb;
    end else begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_wstrb = wstrb;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
      @(negedge ACLK);
    end
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
    check_output("accept", 32'(got), 32'h1);
    for (int i = 0; i < 50 && !fin; i++) begin
      #1;
      if ((id ? req1_done : req0_done) === 1'b1) begin
        fin   = 1'b1;
        lat   = cyc - acc_cyc;
        rdata = id ? req1_rdata : req0_rdata;
        resp  = id ? req1_resp : req0_resp;
      end else begin
        @(negedge ACLK);
      end
    end
    check_output("done", 32'(fin), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat;
    int          n;
    logic [3:0]  seq;
    bit          both;
    bit          saw;
    int          a0, w0, b0;
    logic [3:0]  sw_addr [4];
    logic [31:0] sw_awexp [4];

    ARESET = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 4'h0; req0_wdata = 32'h0; req0_wstrb = 4'h0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 4'h0; req1_wdata = 32'h0; req1_wstrb = 4'h0;
    repeat (3) @(negedge ACLK);
    #1;
    check_output("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'h0);
    check_output("rst_pulses", 32'({req0_ready, req1_ready, req0_done, req1_done}), 32'h0);
    check_output("rst_rdata0", req0_rdata, 32'h0);
    check_output("rst_rdata1", req1_rdata, 32'h0);
    check_output("rst_resp", 32'({req0_resp, req1_resp}), 32'h0);
    check_output("rst_addr", 32'({m_axi_awaddr, m_axi_araddr, m_axi_wstrb}), 32'h0);
    check_output("rst_wdata", m_axi_wdata, 32'h0);
    @(negedge ACLK);
    ARESET = 1'b0;

    $display("[TB] tie-break after reset");
    @(negedge ACLK);
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 4'h0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 4'h4;
    #1;
    check_output("tie_first", 32'({req1_ready, req0_ready}), 32'h1);
    n = 0; seq = 4'h0; both = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready || req1_ready) begin
        seq[n] = req1_ready;
        n++;
      end
      @(negedge ACLK);
      #1;
      if (n == 4) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_output("tie_count", 32'(n), 32'h4);
    check_output("tie_seq", 32'(seq), 32'hA);
    check_output("tie_both", 32'(both), 32'h0);
    repeat (6) @(negedge ACLK);

    $display("[TB] write then read");
    apply_stimulus(1'b0, 1'b1, 4'h4, 32'h0000_0002, 4'hF, rd, rs, lat);
    check_output("wr_resp", 32'(rs), 32'h0);
    check_output("wr_lat", lat, 32'h3);
    check_output("wr_awaddr", 32'(cap_awaddr), 32'h4);
    check_output("wr_wdata", cap_wdata, 32'h2);
    check_output("prot", 32'({m_axi_awprot, m_axi_arprot}), 32'h0);
    apply_stimulus(1'b0, 1'b0, 4'h4, 32'h0, 4'h0, rd, rs, lat);
    check_output("rd_data", rd, 32'h2);
    check_output("rd_resp", 32'(rs), 32'h0);
    check_output("rd_lat", lat, 32'h3);
    check_output("rd_araddr", 32'(cap_araddr), 32'h4);
    repeat (2) @(negedge ACLK);
    check_output("rdata_hold", req0_rdata, 32'h2);

    $display("[TB] four-register sweep");
    sw_addr  = '{4'h0, 4'h4, 4'h8, 4'hE};
    sw_awexp = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(bit'(i % 2), 1'b1, sw_addr[i], 32'(i + 1), 4'hF, rd, rs, lat);
      check_output("sweep_wr_resp", 32'(rs), 32'h0);
      check_output("sweep_awaddr", 32'(cap_awaddr), sw_awexp[i]);
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(bit'((i + 1) % 2), 1'b0, sw_addr[i], 32'h0, 4'h0, rd, rs, lat);
      check_output("sweep_rd", rd, 32'(i + 1));
      check_output("sweep_reg", regs[i], 32'(i + 1));
    end

    $display("[TB] independent AW/W handshakes");
    w_wait = 3;
    a0 = aw_cycles; w0 = w_cycles; b0 = b_hs_n;
    apply_stimulus(1'b1, 1'b1, 4'h8, 32'hA5A5_0F0F, 4'h3, rd, rs, lat);
    check_output("indep_done_after_b", cyc - b_hs_cyc, 32'h1);
    check_output("indep_lat", lat, 32'h6);
    repeat (3) @(negedge ACLK);
    check_output("indep_aw_cycles", aw_cycles - a0, 32'h1);
    check_output("indep_w_cycles", w_cycles - w0, 32'h4);
    check_output("indep_b_count", b_hs_n - b0, 32'h1);
    check_output("indep_wstrb", 32'(cap_wstrb), 32'h3);
    check_output("indep_reg2", regs[2], 32'h0000_0F0F);
    w_wait = 0;
    apply_stimulus(1'b0, 1'b0, 4'h8, 32'h0, 4'h0, rd, rs, lat);
    check_output("indep_readback", rd, 32'h0000_0F0F);

    $display("[TB] error passthrough");
    rresp_cfg = 2'b10;
    apply_stimulus(1'b1, 1'b0, 4'hC, 32'h0, 4'h0, rd, rs, lat);
    check_output("err_resp", 32'(rs), 32'h2);
    check_output("err_rdata", rd, 32'h4);
    rresp_cfg = 2'b00;

    $display("[TB] reset mid-transaction");
    r_stall = 1'b1;
    @(negedge ACLK);
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 4'h4;
    #1;
    check_output("mid_accept", 32'(req0_ready), 32'h1);
    @(negedge ACLK);
    req0_valid = 1'b0;
    @(negedge ACLK);
    #1;
    check_output("mid_rready", 32'(m_axi_rready), 32'h1);
    ARESET = 1'b1;
    #1;
    check_output("mid_clear", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                                   m_axi_rready, req0_ready, req1_ready}), 32'h0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      #1;
      if (req0_done || req1_done) saw = 1'b1;
    end
    ARESET = 1'b0;
    r_stall = 1'b0;
    repeat (4) begin
      @(negedge ACLK);
      #1;
      if (req0_done || req1_done) saw = 1'b1;
    end
    check_output("mid_no_done", 32'(saw), 32'h0);
    check_output("mid_rdata0", req0_rdata, 32'h0);
    check_output("mid_rdata1", req1_rdata, 32'h0);
    apply_stimulus(1'b0, 1'b0, 4'h8, 32'h0, 4'h0, rd, rs, lat);
    check_output("post_rst_rd", rd, 32'h0000_0F0F);
    check_output("post_rst_resp", 32'(rs), 32'h0);
    check_output("post_rst_lat", lat, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
